// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_RUN  = 2'd1;
    localparam mdu_state_t ST_FIX  = 2'd2;
    localparam mdu_state_t ST_DONE = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negator used for operand magnitudes and result sign fix-up.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? -a_i : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs_i,
    input  logic [N-1:0] rt_i,
    input  logic         hi_we_i,
    input  logic         lo_we_i,
    input  logic [N-1:0] wdata_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div_by_zero_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mdu_state_t     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           is_div_q, is_div_d;
    logic           sign_x_q, sign_x_d;
    logic           sign_r_q, sign_r_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   rs_raw_q, rs_raw_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;

    logic           in_signed;
    logic [N-1:0]   abs_rs, abs_rt;
    logic [2*N-1:0] prod_fixed;
    logic [N-1:0]   quo_fixed, rem_fixed;
    logic           accepting, accept;
    logic [N:0]     mul_sum;
    logic [N:0]     div_sh;
    logic [N+1:0]   div_diff;
    logic [2*N-1:0] mul_next, div_next;

    assign in_signed = ~op_i[0];
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = accepting && start_i;

    mdu_negate #(.W(N)) u_abs_rs (.neg_i(in_signed & rs_i[N-1]), .a_i(rs_i), .y_o(abs_rs));
    mdu_negate #(.W(N)) u_abs_rt (.neg_i(in_signed & rt_i[N-1]), .a_i(rt_i), .y_o(abs_rt));

    mdu_negate #(.W(2*N)) u_fix_prod (.neg_i(sign_x_q), .a_i(acc_q), .y_o(prod_fixed));
    mdu_negate #(.W(N)) u_fix_quo (.neg_i(sign_x_q), .a_i(acc_q[N-1:0]), .y_o(quo_fixed));
    mdu_negate #(.W(N)) u_fix_rem (.neg_i(sign_r_q), .a_i(acc_q[2*N-1:N]), .y_o(rem_fixed));

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    // Divide: the accumulator holds {remainder, dividend/quotient}; shift left and try-subtract.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        mul_next = {mul_sum, acc_q[N-1:1]};
        div_sh   = acc_q[2*N-1:N-1];
        div_diff = {1'b0, div_sh} - {2'b00, mcand_q};
        div_next = div_diff[N+1] ? {div_sh[N-1:0], acc_q[N-2:0], 1'b0}
                                 : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        sign_x_d = sign_x_q;
        sign_r_d = sign_r_q;
        dbz_d    = dbz_q;
        mcand_d  = mcand_q;
        rs_raw_d = rs_raw_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (is_div_q) begin
                    hi_d = dbz_q ? rs_raw_q : rem_fixed;
                    lo_d = dbz_q ? {N{1'b1}} : quo_fixed;
                end else begin
                    hi_d = prod_fixed[2*N-1:N];
                    lo_d = prod_fixed[N-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d  = ST_RUN;
                    count_d  = '0;
                    is_div_d = op_i[1];
                    sign_x_d = in_signed & (rs_i[N-1] ^ rt_i[N-1]);
                    sign_r_d = in_signed & rs_i[N-1];
                    dbz_d    = op_i[1] & (rt_i == '0);
                    rs_raw_d = rs_i;
                    mcand_d  = op_i[1] ? abs_rt : abs_rs;
                    acc_d    = {{N{1'b0}}, (op_i[1] ? abs_rs : abs_rt)};
                end else begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            sign_x_q <= 1'b0;
            sign_r_q <= 1'b0;
            dbz_q    <= 1'b0;
            mcand_q  <= '0;
            rs_raw_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            sign_x_q <= sign_x_d;
            sign_r_q <= sign_r_d;
            dbz_q    <= dbz_d;
            mcand_q  <= mcand_d;
            rs_raw_q <= rs_raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o        = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done_o        = (state_q == ST_DONE);
    assign div_by_zero_o = done_o & dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO, a monitor checks on done_o.
module tb_mult_div_unit;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         start_i;
    logic [1:0]   op_i;
    logic [N-1:0] rs_i;
    logic [N-1:0] rt_i;
    logic         hi_we_i;
    logic         lo_we_i;
    logic [N-1:0] wdata_i;
    logic         busy_o;
    logic         done_o;
    logic         div_by_zero_o;
    logic [N-1:0] hi_o;
    logic [N-1:0] lo_o;

    typedef struct packed {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mult_div_unit #(.N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .op_i          (op_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .hi_we_i       (hi_we_i),
        .lo_we_i       (lo_we_i),
        .wdata_i       (wdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: compare every done_o pulse against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h want no done", hi_o, lo_o);
            end else begin
                e = exp_q.pop_front();
                if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero_o !== e.dbz) begin
                    bad++;
                    $display("FAIL result: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                             hi_o, lo_o, div_by_zero_o, e.hi, e.lo, e.dbz);
                end else begin
                    $display("txn hi=%h lo=%h dbz=%b ok", hi_o, lo_o, div_by_zero_o);
                end
            end
        end else if (div_by_zero_o) begin
            total++;
            bad++;
            $display("FAIL dbz_without_done: got 1 want 0");
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic edbz,
                          input bit push);
        exp_t e;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz;
            exp_q.push_back(e);
        end
        start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int inject_at, input int reset_at);
        int cnt;
        bit seen;
        logic [N-1:0] hi_before;
        seen = 0;
        cnt  = 1;
        hi_before = '0;
        while (cnt <= 40 && !seen) begin
            if (cnt == reset_at) begin
                reset = 1'b0;
                #1;
                check("abort_hi", hi_o, '0);
                check("abort_lo", lo_o, '0);
                check("abort_busy", {31'd0, busy_o}, 32'd0);
                return;
            end
            if (cnt == inject_at) begin
                hi_before = hi_o;
                start_i = 1'b1; op_i = 2'b11; hi_we_i = 1'b1; wdata_i = 32'h0000_DEAD;
            end
            @(negedge clk);
            if (cnt == inject_at) begin
                start_i = 1'b0; hi_we_i = 1'b0;
                check("inject_hi_kept", hi_o, hi_before);
                check("inject_busy", {31'd0, busy_o}, 32'd1);
            end
            if (cnt == 1) check("busy_edge1", {31'd0, busy_o}, 32'd1);
            if (cnt == N) check("busy_edgeN", {31'd0, busy_o}, 32'd1);
            if (done_o) begin
                seen = 1;
                check("latency", cnt, N + 1);
                check("busy_at_done", {31'd0, busy_o}, 32'd0);
            end
            cnt++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done_o want done within 40 edges");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start_i = 1'b0; op_i = 2'b00; rs_i = '0; rt_i = '0;
        hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", hi_o, '0);
        check("reset_lo", lo_o, '0);
        check("reset_flags", {29'd0, busy_o, done_o, div_by_zero_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
        @(negedge clk);
        hi_we_i = 1'b0;
        check("mthi_hi", hi_o, 32'h0000_1234);
        check("mthi_lo", lo_o, 32'h0000_0000);

        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_A5A5;
        @(negedge clk);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        check("mtboth_hi", hi_o, 32'h0000_A5A5);
        check("mtboth_lo", lo_o, 32'h0000_A5A5);

        // Back-to-back ops: each launch starts from DONE.
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
        wait_done(0, 0);
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);
        wait_done(0, 0);
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
        wait_done(0, 0);
        launch(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1);
        wait_done(0, 0);
        launch(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 1'b0, 1);
        wait_done(0, 0);
        launch(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done(0, 0);
        launch(2'b10, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        wait_done(0, 0);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
        wait_done(0, 0);

        @(negedge clk);
        hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
        @(negedge clk);
        hi_we_i = 1'b0;
        check("mthi_idle", hi_o, 32'h0000_1234);

        launch(2'b01, 32'd5, 32'd6, 32'h0000_0000, 32'd30, 1'b0, 1);
        wait_done(5, 0);
        @(negedge clk);

        // Abort mid-divide with reset; no result may be reported.
        launch(2'b11, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0);
        wait_done(0, 10);
        repeat (3) @(negedge clk);
        check("abort_hold_busy", {31'd0, busy_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        launch(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1);
        wait_done(0, 0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit that sits directly downstream of the 32-entry register file.
- Consumes R[rs] and R[rt] from the two read ports, executes MIPS MULT/MULTU/DIV/DIVU, and holds results in HI/LO registers.
- Also supports MTHI/MTLO writes.
- The control unit stalls on busy_o and reads hi_o/lo_o for MFHI/MFLO.

Parameters:
N, 32, operand and HI/LO width (must be even, >=4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start_i  input  1  launch operation; sampled only when accepting (state IDLE or DONE)
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
rs_i  input  N  R[rs], multiplicand / dividend
rt_i  input  N  R[rt], multiplier / divisor
hi_we_i  input  1  MTHI write enable
lo_we_i  input  1  MTLO write enable
wdata_i  input  N  MTHI/MTLO data (R[rs])
busy_o  output  1  high in RUN and FIX
done_o  output  1  one-cycle pulse in DONE
div_by_zero_o  output  1  pulses with done_o when a DIV/DIVU had rt_i==0
hi_o  output  N  HI register
lo_o  output  N  LO register

Behaviour:
- Reset (reset==0, async):
  - State IDLE; hi_o, lo_o = 0; busy_o, done_o, div_by_zero_o = 0.
  - All internal accumulators and the counter clear.
  - Reset mid-operation aborts with no done_o and no HI/LO update.
- FSM:
  - IDLE -(start_i)-> RUN; RUN -(count==N-1)-> FIX; FIX -> DONE.
  - DONE -(start_i)-> RUN, else IDLE.
  - All transitions occur on clock edges.
- Latency: start accepted at edge E0; RUN iterates on edges E1..EN; FIX commits HI/LO on edge E(N+1); done_o is high in the cycle after E(N+1). For N=32, that is 33 edges after acceptance.
- Accept (E0):
  - Latch op.
  - Signed ops: latch |rs_i|, |rt_i| and the result signs. Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs); product sign = sign(rs) XOR sign(rt).
  - Unsigned ops: latch raw operands.
  - Counter = 0.
- Multiply: radix-2 shift-add over a 2N-bit accumulator, one bit per RUN cycle.
- Divide: restoring divide, one quotient bit per RUN cycle; N-bit remainder plus one carry bit.
- FIX:
  - Apply two's-complement negation per the latched signs (2N-bit for product, N-bit for quotient and remainder).
  - Write HI = product[2N-1:N] / remainder and LO = product[N-1:0] / quotient.
- Divide by zero (rt_i==0 at accept):
  - Operation still runs the full latency.
  - Result HI = rs_i (as latched, unmodified), LO = all-ones.
  - div_by_zero_o pulses with done_o.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (truncated result of the magnitude path); no flag.
- Division truncates toward zero; remainder takes the dividend's sign.
- start_i in RUN or FIX is ignored; no queueing.
- MTHI/MTLO:
  - Applied on the edge only when state is IDLE or DONE and start_i==0.
  - Ignored while busy_o, or when start_i is accepted on the same edge (start has priority).
  - hi_we_i and lo_we_i together write wdata_i to both.
- hi_o and lo_o are stable except on a FIX edge or an applied MT write.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - the FSM state enum (IDLE, RUN, FIX, DONE);
  - the counter width function clog2(N).
- One sub-module is natural: mdu_negate, a parameterised conditional two's-complement negator. It is instantiated for the operand absolutes (width N) and for the FIX-stage product (2N) and quotient/remainder (N).
- The FSM, counter and datapath stay in mult_div_unit.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done_o at edge 33; HI=0xFFFFFFFE, LO=0x00000001; busy_o high edges 1..32.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> HI=0x00000064, LO=0xFFFFFFFF, div_by_zero_o=1 for exactly the done_o cycle.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0; div_by_zero_o=0.
- MTHI 0x1234 in IDLE -> hi_o=0x1234 next cycle. Then start MULTU 5*6 and pulse start_i plus hi_we_i (0xDEAD) at RUN edge 5 -> both ignored; final HI=0, LO=30.
- Start DIVU 1000/3, drive reset low at RUN edge 10 -> hi_o=lo_o=0 and busy_o=0 immediately (async); no done_o. Restart after release -> LO=333, HI=1.
